// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button press classifier: FSM state encoding,
// default 50 MHz timing constants and small elaboration-time helpers.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_e;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_LONG_TICKS   = 1000;
  localparam int DEF_REPEAT_TICKS = 200;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Tick counter must hold the larger threshold without wrapping.
  function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
    return $clog2(max_int(long_ticks, repeat_ticks) + 1);
  endfunction

endpackage

// File: rtl/button_press_classifier_tick_gen.sv
// Free-running prescaler that pulses o_tick once every TICK_DIV clocks.
// A synchronous clear restarts the period so timing can be aligned to an event.
module tick_gen
  import button_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] r_presc;

  assign o_tick = (r_presc == PW'(TICK_DIV - 1));

  // Prescaler: wraps after TICK_DIV-1, clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
    end else if (o_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses as short or long and emits auto-repeat
// pulses while a long press is held. One instance per button.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_level,
  input  logic i_btn_down,
  input  logic i_btn_up,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held
);

  localparam int CNT_W   = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam int CNT_MAX = max_int(LONG_TICKS, REPEAT_TICKS);

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tick;
  logic             w_clr_presc;
  logic             w_short;
  logic             w_long;
  logic             w_repeat;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr_presc),
    .o_tick (w_tick)
  );

  // Saturating increment keeps the counter from ever wrapping.
  assign w_cnt_inc = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : (r_cnt + 1'b1);

  // Next-state, counter and pulse decode; release beats any coincident threshold.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_clr_presc  = 1'b0;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_repeat     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_btn_down) begin
          w_next_state = ST_PRESSED;
          w_cnt_next   = '0;
          w_clr_presc  = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (w_tick) begin
          w_cnt_next = w_cnt_inc;
        end else begin
          w_cnt_next = r_cnt;
        end
        if (i_btn_up) begin
          w_next_state = ST_IDLE;
          w_short      = 1'b1;
        end else if (w_tick && (r_cnt == CNT_W'(LONG_TICKS - 1))) begin
          w_next_state = ST_LONG;
          w_long       = 1'b1;
          w_cnt_next   = '0;
        end else if (!i_btn_level) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_PRESSED;
        end
      end
      ST_LONG: begin
        if (i_btn_up || !i_btn_level) begin
          w_next_state = ST_IDLE;
        end else if (w_tick && (r_cnt == CNT_W'(REPEAT_TICKS - 1))) begin
          w_repeat   = 1'b1;
          w_cnt_next = '0;
        end else if (w_tick) begin
          w_cnt_next = w_cnt_inc;
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, tick counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_short  <= w_short;
      r_long   <= w_long;
      r_repeat <= w_repeat;
      r_held   <= (w_next_state != ST_IDLE);
    end
  end

  assign o_short_press = r_short;
  assign o_long_press  = r_long;
  assign o_repeat      = r_repeat;
  assign o_held        = r_held;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench: directed press scenarios plus random button activity,
// compared each cycle against a time-arithmetic reference model.
module tb_button_press_classifier;

  localparam int TD = 4;
  localparam int LT = 5;
  localparam int RT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;
  logic btn_down = 1'b0;
  logic btn_up = 1'b0;
  logic short_press, long_press, rep, held;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: 0 idle, 1 pressed (short window), 2 long held
  int m_mode = 0;
  int m_t0 = 0;
  int cyc = 0;
  logic e_short, e_long, e_rep, e_held;

  button_press_classifier #(
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_btn_level   (btn_level),
    .i_btn_down    (btn_down),
    .i_btn_up      (btn_up),
    .o_short_press (short_press),
    .o_long_press  (long_press),
    .o_repeat      (rep),
    .o_held        (held)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Long event lands LT*TD cycles after the press; repeats every RT*TD after it.
  task automatic model(input logic dn, input logic up, input logic lvl, input logic rn);
    int d;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    d = cyc - m_t0;
    if (!rn) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (dn) begin
        m_mode = 1;
        m_t0   = cyc;
      end
    end else if (m_mode == 1) begin
      if (up) begin
        e_short = 1'b1;
        m_mode  = 0;
      end else if (d == LT * TD) begin
        e_long = 1'b1;
        m_mode = 2;
      end else if (!lvl) begin
        m_mode = 0;
      end
    end else begin
      if (up || !lvl) begin
        m_mode = 0;
      end else if (d > LT * TD && ((d - LT * TD) % (RT * TD)) == 0) begin
        e_rep = 1'b1;
      end
    end
    e_held = (m_mode != 0);
  endtask

  task automatic step(input logic dn, input logic up, input logic lvl, input logic rn);
    btn_down  = dn;
    btn_up    = up;
    btn_level = lvl;
    rst_n     = rn;
    model(dn, up, lvl, rn);
    @(posedge clk);
    #1;
    cyc++;
    check_eq("short_press", short_press, e_short);
    check_eq("long_press", long_press, e_long);
    check_eq("repeat", rep, e_rep);
    check_eq("held", held, e_held);
    check_eq("exclusive", ((short_press + long_press + rep) <= 1) ? 1 : 0, 1);
  endtask

  // Relative-cycle press scenario; a negative index disables that event.
  task automatic scenario(input int n, input int dn_at, input int up_at,
                          input int drop_at, input int rst_at, input int dn2_at);
    logic lvl;
    logic dn;
    logic up;
    lvl = 1'b0;
    for (int c = 0; c < n; c++) begin
      dn = (c == dn_at) || (c == dn2_at);
      up = (c == up_at);
      if (dn) lvl = 1'b1;
      if (up || c == drop_at) lvl = 1'b0;
      step(dn, up, lvl, (c != rst_at));
    end
    if (lvl) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic lvl;
    logic dn;
    logic up;
    logic rn;
    #1;
    for (int c = 0; c < 3; c++) step((c % 2) == 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("idle_after_reset", held, 0);

    scenario(20, 0, 12, -1, -1, -1);   // short press
    scenario(48, 0, 40, -1, -1, -1);   // long press with repeats
    scenario(28, 0, 20, -1, -1, -1);   // release on threshold tick
    scenario(40, 0, -1, 10, -1, 15);   // lost release, then re-press
    scenario(50, 0, 45, -1, 30, -1);   // reset during long hold

    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      dn = 1'b0;
      up = 1'b0;
      rn = ($urandom_range(499, 0) != 0);
      if (!lvl) begin
        if ($urandom_range(15, 0) == 0) begin
          lvl = 1'b1;
          dn  = 1'b1;
        end
      end else begin
        if ($urandom_range(29, 0) == 0) begin
          lvl = 1'b0;
          up  = ($urandom_range(7, 0) != 0);
        end else if ($urandom_range(39, 0) == 0) begin
          dn = 1'b1;
        end
      end
      step(dn, up, lvl, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Sits directly downstream of the button debouncer on the clock shield. Consumes its synchronized level and its one-cycle down/up pulses.
- Classifies each press as short or long. While a long press is held, emits periodic auto-repeat pulses for time-setting logic (e.g. hours/minutes increment).
- One instance per button.

Parameters:
- TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); legal range >= 2.
- LONG_TICKS, 1000, ticks a press must be held to count as long; legal range >= 1.
- REPEAT_TICKS, 200, ticks between auto-repeat pulses once long; legal range >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- btn_level  in  1  debounced button level, 1 = pressed
- btn_down  in  1  one-cycle press pulse from debouncer
- btn_up  in  1  one-cycle release pulse from debouncer
- short_press  out  1  one-cycle pulse: released before long threshold
- long_press  out  1  one-cycle pulse: long threshold reached while held
- repeat  out  1  one-cycle pulse every REPEAT_TICKS ticks after long_press while held
- held  out  1  registered, high while state != IDLE

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is synchronous and active-low, sampled only on posedge clk.
- Reset values: state = IDLE, prescaler = 0, tick counter = 0. All outputs 0.
- Reset mid-press: go to IDLE. No pulse is emitted, either on reset or on the following release.
- All outputs are registered. A pulse is high for exactly one cycle, in the cycle after the triggering event cycle.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is asserted when prescaler == TICK_DIV-1. Prescaler is cleared to 0 on the IDLE->PRESSED transition.
- Tick counter: width $clog2(max(LONG_TICKS,REPEAT_TICKS)+1). Counts ticks and never wraps.
- FSM IDLE:
  - btn_down = 1 -> PRESSED; clear prescaler and counter.
  - btn_up is ignored.
- FSM PRESSED:
  - On tick, counter increments.
  - btn_up = 1 -> IDLE, short_press.
  - Otherwise, if tick and counter == LONG_TICKS-1 -> LONG_HELD, long_press, counter cleared.
  - Otherwise, if btn_level == 0 (lost up pulse) -> IDLE, no pulse.
- FSM LONG_HELD:
  - Prescaler keeps running (not cleared).
  - On tick, counter increments. When tick and counter == REPEAT_TICKS-1 -> repeat pulse, counter cleared, stay in LONG_HELD.
  - btn_up = 1 or btn_level == 0 -> IDLE, no pulse. Release has priority over a coincident repeat tick; repeat is suppressed.
- Simultaneous btn_up and the long-threshold tick in PRESSED: release wins. short_press = 1, long_press = 0.
- btn_down outside IDLE: ignored; it does not restart timing.
- short_press, long_press and repeat are mutually exclusive. Never two in one cycle.
- Timing: if btn_down is at cycle 0 and the button stays held:
  - long_press is high at cycle LONG_TICKS*TICK_DIV + 1.
  - repeats follow every REPEAT_TICKS*TICK_DIV cycles after that.

Decomposition:
- Shared package button_pkg holds:
  - state typedef / localparams: ST_IDLE = 2'd0, ST_PRESSED = 2'd1, ST_LONG = 2'd2.
  - default timing constants for the 50 MHz clock.
- Sub-module tick_gen (prescaler with sync clear input and tick output) is natural; it is reusable by the display blink logic.
- FSM and tick counter stay in button_press_classifier.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV = 4, LONG_TICKS = 5, REPEAT_TICKS = 2.
- Reset: rst_n = 0 for 3 cycles with btn_down pulsing -> all outputs 0, held = 0. First cycle after release, state is IDLE.
- Short press: btn_down @0, btn_up @12 -> held = 1 on cycles 1..12, short_press = 1 @13 only. No long_press or repeat.
- Long press with repeat: btn_down @0, level held until btn_up @40 ->
  - long_press @21.
  - repeat @29 and @37.
  - held = 0 @41, no short_press.
- Threshold race: btn_down @0, btn_up @20 (coincides with 5th tick) -> short_press @21, long_press never asserted.
- Lost release: btn_down @0, btn_level drops @10 with no btn_up -> state IDLE @11, held = 0 @11, no pulses. A new btn_down @15 gives long_press @36 if held.
- Reset mid-repeat: rst_n = 0 @30 during LONG_HELD -> no repeat @37, all outputs 0 from @31. A later btn_up produces nothing.
